rr_packet_arbiter: RTL

- Shares one ready/valid output stream among NUM_REQ ready/valid requesters.
- Arbitration is round-robin at packet granularity. A granted requester keeps the output until it transfers a beat with last_in set.
- The output is a one-entry registered forward stage: valid_out, data_out, last_out and grant_id_out all come from flops. Upstream ready to the winner is ~full | ready_in.
- Sits in front of a single shared consumer, such as a link, memory port or register-slice chain.

---
 rtl/rr_packet_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin, packet-granular arbiter that shares one
// ready/valid output stream among NUM_REQ requesters. The output is a
// one-entry registered forward stage; a granted requester holds the output
// until it transfers a beat with last set.
module rr_packet_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]            last_in,
    output logic [NUM_REQ-1:0]            ready_out,
    output logic                          valid_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          last_out,
    output logic [ID_WIDTH-1:0]           grant_id_out,
    input  logic                          ready_in
);

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} st_e;

    // Widened constants so the wrap compare is against NUM_REQ, not a
    // power-of-two truncation.
    localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

    // Per-requester view of the flattened payload bus.
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;
    assign data_arr = data_in;

    st_e                   st_q, st_d;
    logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    logic [ID_WIDTH-1:0]   sel;
    logic                  sel_vld;
    logic [ID_WIDTH:0]     idx;
    logic                  can_load;
    logic                  xfer;

    // Output stage may take a new beat when empty or when it drains this cycle.
    assign can_load = ~full_q | ready_in;
    assign xfer     = sel_vld & can_load;

    // State register: arbitration state, pointers and the output buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= ARB;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            full_q    <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            id_q      <= '0;
        end else begin
            st_q      <= st_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            full_q    <= full_d;
            data_q    <= data_d;
            last_q    <= last_d;
            id_q      <= id_d;
        end
    end

    // Next state: load the winner's beat, track packet lock and advance the
    // round-robin pointer only at end of packet.
    always_comb begin
        st_d      = st_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        full_d    = full_q;
        data_d    = data_q;
        last_d    = last_q;
        id_d      = id_q;
        if (xfer) begin
            full_d = 1'b1;
            data_d = data_arr[sel];
            last_d = last_in[sel];
            id_d   = sel;
            if (!last_in[sel]) begin
                st_d      = LOCK;
                lock_id_d = sel;
            end else begin
                st_d     = ARB;
                rr_ptr_d = (sel == LAST_ID) ? '0 : sel + 1'b1;
            end
        end else if (full_q && ready_in) begin
            full_d = 1'b0;
        end
    end

    // Output decode: pick the requester (locked owner, or first valid from
    // rr_ptr with wrap) and raise its ready when the stage can load.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        if (st_q == LOCK) begin
            sel     = lock_id_q;
            sel_vld = valid_in[lock_id_q];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
                if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
                if (!sel_vld && valid_in[idx[ID_WIDTH-1:0]]) begin
                    sel     = idx[ID_WIDTH-1:0];
                    sel_vld = 1'b1;
                end
            end
        end
    end

    // One-hot (or zero) ready back to the selected requester.
    always_comb begin
        ready_out = '0;
        if (xfer) ready_out[sel] = 1'b1;
    end

    assign valid_out    = full_q;
    assign data_out     = data_q;
    assign last_out     = last_q;
    assign grant_id_out = id_q;

endmodule
